// File: rtl/iomem_pwm_leds.sv
// rtl/iomem_pwm_leds.sv - memory-mapped 8-channel PWM LED controller on the picosoc iomem bus
// Duty values are shadowed and only reloaded at period wrap (or continuously while disabled).
module iomem_pwm_leds #(
  parameter logic [7:0] ADDR_HI = 8'h04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [7:0]  pwm_out
);

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_DUTY0    = 3'd2;
  localparam logic [2:0] REG_DUTY1    = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  logic        en;
  logic [7:0]  inv;
  logic [15:0] prescale;
  logic [31:0] duty0;
  logic [31:0] duty1;
  logic        wrap_flag;

  logic [15:0] pcnt;
  logic [7:0]  cnt;
  logic [63:0] shadow;

  logic        accept;
  logic        wr;
  logic [2:0]  sel;
  logic        tick;
  logic        wrap;
  logic [31:0] rd_mux;
  logic [7:0]  pwm_next;
  logic        unused_addr;

  assign accept = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_HI);
  assign wr     = accept && (iomem_wstrb != 4'b0000);
  assign sel    = iomem_addr[4:2];
  assign tick   = en && (pcnt == prescale);
  assign wrap   = tick && (cnt == 8'd254);

  assign unused_addr = ^{iomem_addr[23:5], iomem_addr[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    rd_mux = 32'h0;
    case (sel)
      REG_CTRL:     rd_mux = {16'h0, inv, 7'h0, en};
      REG_PRESCALE: rd_mux = {16'h0, prescale};
      REG_DUTY0:    rd_mux = duty0;
      REG_DUTY1:    rd_mux = duty1;
      REG_STATUS:   rd_mux = {23'h0, wrap_flag, cnt};
      default:      rd_mux = 32'h0;
    endcase
  end

  // Read data is sampled at acceptance, so it always shows the pre-write contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'h0;
    end else begin
      iomem_ready <= accept;
      iomem_rdata <= accept ? rd_mux : 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en       <= 1'b0;
      inv      <= 8'h00;
      prescale <= 16'h0000;
      duty0    <= 32'h0;
      duty1    <= 32'h0;
    end else if (wr) begin
      case (sel)
        REG_CTRL: begin
          if (iomem_wstrb[0]) en  <= iomem_wdata[0];
          if (iomem_wstrb[1]) inv <= iomem_wdata[15:8];
        end
        REG_PRESCALE: begin
          if (iomem_wstrb[0]) prescale[7:0]  <= iomem_wdata[7:0];
          if (iomem_wstrb[1]) prescale[15:8] <= iomem_wdata[15:8];
        end
        REG_DUTY0: duty0 <= merge_bytes(duty0, iomem_wdata, iomem_wstrb);
        REG_DUTY1: duty1 <= merge_bytes(duty1, iomem_wdata, iomem_wstrb);
        default: ;
      endcase
    end
  end

  // A wrap on the same edge as a W1C clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_flag <= 1'b0;
    end else if (wrap) begin
      wrap_flag <= 1'b1;
    end else if (wr && (sel == REG_STATUS) && iomem_wstrb[1] && iomem_wdata[8]) begin
      wrap_flag <= 1'b0;
    end
  end

  // pcnt free-runs through 0xFFFF if PRESCALE is lowered beneath it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= 16'h0000;
      cnt  <= 8'h00;
    end else if (!en) begin
      pcnt <= 16'h0000;
      cnt  <= 8'h00;
    end else begin
      pcnt <= tick ? 16'h0000 : pcnt + 16'd1;
      if (tick) begin
        cnt <= (cnt == 8'd254) ? 8'h00 : cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= 64'h0;
    end else if (!en || wrap) begin
      shadow <= {duty1, duty0};
    end
  end

  always_comb begin
    pwm_next = 8'h00;
    for (int i = 0; i < 8; i++) begin
      pwm_next[i] = ((cnt < shadow[8*i +: 8]) & en) ^ inv[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out <= 8'h00;
    end else begin
      pwm_out <= pwm_next;
    end
  end

endmodule

// File: doc/iomem_pwm_leds.md
# iomem_pwm_leds

Memory-mapped 8-channel PWM LED controller that sits on the picosoc `iomem` bus next to the GPIO register and drives the board LEDs with per-channel brightness. It decodes one address region, provides prescaler/duty/control/status registers, and generates glitch-free 8-bit PWM. Duty updates are shadowed to period boundaries. Outputs feed the LED pins directly, with a per-channel invert for active-low LEDs such as `ledr_n` and `ledg_n`.

## Interface
- `ADDR_HI`, default `8'h04`, value of `iomem_addr[31:24]` that selects this block.
- `clk` in 1: sole clock, all logic on posedge.
- `reset` in 1: asynchronous, active-high reset.
- `iomem_valid` in 1: bus request.
- `iomem_ready` out 1: one-cycle access acknowledge.
- `iomem_wstrb` in 4: byte write strobes; 0 means read.
- `iomem_addr` in 32: byte address; bits [4:2] select the register.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data, valid while `iomem_ready` = 1.
- `pwm_out` out 8: PWM outputs, registered.

## Operation
- Registers (offset, reset value):
  - 0x00 CTRL: [0] EN, [15:8] INV mask (reset 0).
  - 0x04 PRESCALE: [15:0] (reset 0).
  - 0x08 DUTY0: bytes = ch0..ch3 (reset 0).
  - 0x0C DUTY1: bytes = ch4..ch7 (reset 0).
  - 0x10 STATUS: [7:0] period counter (RO), [8] WRAP sticky flag (W1C).
  - Offsets 0x14–0x1C: reads return 0; writes are ignored.
- Writes honour `iomem_wstrb` per byte. Unused bits read 0.
- Prescaler: 16-bit `pcnt`. When `pcnt == PRESCALE`, it clears and generates `tick`; otherwise it increments.
- Period counter `cnt` runs 0..254 and advances on `tick`. It wraps 254→0, giving 255 steps per period.
- At wrap (`tick` while `cnt == 254`):
  - shadow duty[7:0][7:0] is loaded from DUTY0/DUTY1;
  - WRAP is set.
- Channel output: `pwm_out[i] <= ((cnt < shadow[i]) & EN) ^ INV[i]`.
  - Duty 0 is always off; duty 255 is always on; duty d is on for d of 255 ticks.
- EN = 0:
  - `pcnt` and `cnt` are held at 0;
  - shadow tracks DUTY every cycle;
  - outputs are at the off level (INV).
- EN 0→1: counting starts from 0 with the current duty values.
- INV changes take effect on the next output register update, independent of the period boundary.
- Simultaneous events:
  - DUTY write in the same cycle as a wrap: shadow takes the pre-write value; the new value loads at the next wrap.
  - WRAP set and W1C clear in the same cycle: set wins.
  - PRESCALE written below the current `pcnt`: `pcnt` continues counting to 0xFFFF, wraps, then matches.
- Reset asserted mid-period: all registers, counters and outputs clear asynchronously. After deassertion the block idles with EN = 0.

## Timing
- Access is accepted on a cycle where `iomem_valid && !iomem_ready && iomem_addr[31:24]==ADDR_HI`.
- `iomem_ready` goes high exactly 1 cycle after acceptance for exactly 1 cycle, then low. Back-to-back accesses therefore take at least 2 cycles each.
- `iomem_rdata` is captured at acceptance and reflects pre-write register contents.
- A write takes effect on the clock edge where `iomem_ready` rises. Its effect is visible on `pwm_out` one cycle later.
- A foreign `ADDR_HI` never asserts `iomem_ready` and never alters state.
- PWM period = 255 × (PRESCALE+1) clocks. `pwm_out` lags `cnt` by 1 clock.
- Reset values: `iomem_ready`=0, `iomem_rdata`=0, `pwm_out`=8'h00.

## Test plan
- Reset, then read all offsets 0x00–0x1C. Required: `iomem_ready` 1 cycle after valid every time; all reads 0; `pwm_out`=0.
- PRESCALE=0, DUTY0=0x00_FF_80_01, EN=1, count over one period. Required high counts: ch0=1, ch1=128, ch2=255 (constant 1), ch3=0.
- PRESCALE=3, ch0 duty 10. Required: `pwm_out[0]` high for 40 clocks of every 1020-clock period.
- Write duty 200 to ch4 mid-period, including a write landing exactly on the wrap cycle. Required: the old duty persists until the next wrap boundary, then 200.
- Write INV=0xC0 with EN=0. Required: `pwm_out`=0xC0. Then EN=1 with duty6=255 → `pwm_out[6]`=0.
- After a wrap, STATUS[8]=1. Write 0x100 → STATUS[8] reads 0. W1C coincident with a wrap → STATUS[8] stays 1. Assert reset mid-period → all outputs 0 immediately, asynchronous to `clk`.
